lsu_mem_port: RTL
=================

Name: lsu_mem_port

Overview:
- Memory-stage load/store port. Consumes the store-size code (StoreSrc) and load-part code (LoadPart) produced by the decoder and runs the transaction on the data-memory bus.
- Drives a single-outstanding req/ready bus handshake, with byte enables and lane-replicated write data.
- Aligns and extends load data for writeback.
- Stalls the pipeline until the access completes.

Parameters:
- ADDR_W, 32, byte-address width.
- TIMEOUT_CYCLES, 16, cycles in REQ without ready before a bus error is raised; 0 disables the timeout.

Ports:
- clk  in  1  core clock.
- reset_n  in  1  synchronous active-low reset.
- mem_read_m  in  1  M-stage load (ResultSrc==01).
- mem_write_m  in  1  M-stage store.
- store_src_m  in  2  00=SW, 01=SH, 10=SB, 11=illegal.
- load_part_m  in  3  000=LB, 001=LH, 010=LW, 100=LBU, 101=LHU; others illegal.
- addr_m  in  ADDR_W  byte address from the ALU.
- wdata_m  in  32  store data (rs2).
- stall_m  out  1  hold IF/ID/EX/M.
- load_data  out  32  aligned and extended load result.
- load_valid  out  1  one-cycle pulse; load_data is valid.
- bus_err  out  1  one-cycle pulse on timeout.
- bus_req  out  1  request.
- bus_we  out  1  write.
- bus_addr  out  ADDR_W  word-aligned address ([1:0]=00).
- bus_be  out  4  byte enables.
- bus_wdata  out  32  write data.
- bus_ready  in  1  completion, sampled while bus_req=1.
- bus_rdata  in  32  read word, valid with bus_ready.
- misalign  out  1  one-cycle pulse, present only with the optional feature.

Behaviour:
- Reset: reset_n is sampled only on the rising clk edge. All outputs are 0, state=IDLE, counter=0. Reset asserted mid-transaction aborts it: bus_req drops on the next edge and no load_valid or bus_err is produced.
- FSM has three states:
  - IDLE: when mem_read_m|mem_write_m, capture op/addr/wdata/codes into registers and go to REQ.
  - REQ: bus_req=1 with registered bus fields held stable. When bus_ready=1, capture bus_rdata and go to DONE. If the counter reaches TIMEOUT_CYCLES, go to DONE and pulse bus_err.
  - DONE: load_valid=1 for loads; go to IDLE.
- stall_m is combinational: high in IDLE when an op is present, and high throughout REQ. It is low in DONE, so the pipeline advances exactly once per op.
- Minimum latency is 3 cycles: op seen → REQ → ready in the same cycle → DONE.
- If mem_read_m and mem_write_m are both high, the store takes priority.
- Illegal codes: the op is treated as a no-op. No request is issued, stall_m stays 0, no pulses are produced.
- Store lanes:
  - SB: be = 1<<addr[1:0]; wdata = {4{wdata[7:0]}}.
  - SH: be = addr[1] ? 1100 : 0011; wdata = {2{wdata[15:0]}}.
  - SW: be = 1111.
  - Loads drive bus_be=1111 and bus_we=0.
- Load extraction uses registered addr[1:0]:
  - LB/LBU select the byte; LH/LHU select the halfword at addr[1]; LW takes the whole word.
  - LB and LH sign-extend; LBU and LHU zero-extend.
- Timeout: the counter increments each REQ cycle without ready and clears on leaving REQ. On timeout, load_data=0 and load_valid=0.
- load_data holds its last value between pulses.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Enabled:
  - An SH with addr[0]=1, an LH/LHU with addr[0]=1, or a word access with addr[1:0]!=0 is not issued.
  - misalign pulses in the op cycle, stall_m stays 0 and load_valid stays 0.
- Disabled:
  - The misalign port is absent.
  - Low address bits below the access size are ignored: SH and LH/LHU use addr[1]; SW and LW use the word.

Decomposition:
- lsu_pkg holds:
  - store_src_e and load_part_e enums with the encodings above;
  - lsu_state_e {IDLE, REQ, DONE};
  - the byte-enable constants.
- Sub-module lsu_load_align: combinational (rdata, offset, load_part) → load_data. It is reused by a future cache refill path.

Test Plan:
- SB at addr 0x103, wdata 0x000000A5, ready on the first REQ cycle → bus_addr 0x100, be 1000, wdata 0xA5A5A5A5; stall_m high for 2 cycles.
- LB at 0x101 with rdata 0x0000F000 → load_data 0xFFFFFFF0. LBU with the same stimulus → 0x000000F0. Each gives a single load_valid pulse.
- LHU at 0x002 with rdata 0x8001_1234 → 0x00008001. LH with the same stimulus → 0xFFFF8001.
- LW with bus_ready held low, TIMEOUT_CYCLES=16 → bus_err pulses after 16 REQ cycles, bus_req drops, no load_valid.
- Reset asserted during REQ with ready low → next cycle bus_req=0 and stall_m=0. A following SW with ready=1 completes normally with be 1111.
- With LSU_MISALIGN_TRAP_EN, SW at 0x102 → misalign pulses, no bus_req, stall_m=0. Without the macro, the same op issues bus_addr 0x100, be 1111.

Source files
------------

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared types and constants for the load/store memory port:
//               store-size and load-part codes, port FSM states, byte-enable
//               patterns and a load-code legality helper.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    // Store size code from the decoder
    typedef enum logic [1:0] {
        SS_SW  = 2'b00,
        SS_SH  = 2'b01,
        SS_SB  = 2'b10,
        SS_ILL = 2'b11
    } store_src_e;

    // Load part code from the decoder; the unlisted encodings are illegal
    typedef enum logic [2:0] {
        LP_LB  = 3'b000,
        LP_LH  = 3'b001,
        LP_LW  = 3'b010,
        LP_LBU = 3'b100,
        LP_LHU = 3'b101
    } load_part_e;

    // Memory port transaction states
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DONE = 2'b10
    } lsu_state_e;

    // Byte-enable patterns
    localparam logic [3:0] c_BE_WORD    = 4'b1111;
    localparam logic [3:0] c_BE_HALF_LO = 4'b0011;
    localparam logic [3:0] c_BE_HALF_HI = 4'b1100;
    localparam logic [3:0] c_BE_BYTE0   = 4'b0001;

    // True for the five defined load part encodings
    function automatic logic load_part_legal(input logic [2:0] lp);
        logic ok;
        case (lp)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ok = 1'b1;
            default:                                ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_load_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_load_align
// Description : Combinational load-data aligner. Selects the byte, halfword
//               or word addressed by the low offset bits of a read word and
//               sign- or zero-extends it to 32 bits. Shared with the cache
//               refill path, so it carries no state.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  load_part_e  load_part,
    output logic [31:0] load_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Pick the addressed lane, then extend according to the load part
    always_comb begin
        w_byte    = rdata[7:0];
        w_half    = offset[1] ? rdata[31:16] : rdata[15:0];
        load_data = rdata;

        case (offset)
            2'd0:    w_byte = rdata[7:0];
            2'd1:    w_byte = rdata[15:8];
            2'd2:    w_byte = rdata[23:16];
            default: w_byte = rdata[31:24];
        endcase

        case (load_part)
            LP_LB:   load_data = {{24{w_byte[7]}}, w_byte};
            LP_LBU:  load_data = {24'h000000, w_byte};
            LP_LH:   load_data = {{16{w_half[15]}}, w_half};
            LP_LHU:  load_data = {16'h0000, w_half};
            default: load_data = rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_mem_port.sv
`default_nettype none
// ============================================================================
// Module      : lsu_mem_port
// Description : Memory-stage load/store port. Runs one outstanding req/ready
//               transaction per M-stage op, drives byte enables and
//               lane-replicated store data, aligns/extends load data and
//               stalls the pipeline until the access completes. A bus that
//               never answers is abandoned after TIMEOUT_CYCLES with bus_err.
//               Optional: define LSU_MISALIGN_TRAP_EN to refuse misaligned
//               halfword/word accesses and pulse the misalign output.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_mem_port
    import lsu_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              mem_read_m,
    input  logic              mem_write_m,
    input  logic [1:0]        store_src_m,
    input  logic [2:0]        load_part_m,
    input  logic [ADDR_W-1:0] addr_m,
    input  logic [31:0]       wdata_m,
    output logic              stall_m,
    output logic [31:0]       load_data,
    output logic              load_valid,
    output logic              bus_err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ready,
    input  logic [31:0]       bus_rdata
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    output logic              misalign
`endif
);

    localparam int c_CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_TIMEOUT = c_CNT_W'(TIMEOUT_CYCLES);

    lsu_state_e          state_q, state_d;
    logic [c_CNT_W-1:0]  cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [3:0]          be_q, be_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [2:0]          load_part_q, load_part_d;
    logic [31:0]         load_data_q, load_data_d;
    logic                load_valid_q, load_valid_d;
    logic                bus_err_q, bus_err_d;

    logic                w_is_store;
    logic                w_is_load;
    logic                w_legal;
    logic                w_issue;
    logic [3:0]          w_st_be;
    logic [31:0]         w_st_wdata;
    logic [c_CNT_W-1:0]  w_cnt_inc;
    logic                w_timeout;
    logic [31:0]         w_aligned;
`ifdef LSU_MISALIGN_TRAP_EN
    logic                w_misaligned;
`endif

    // Aligner works on the live read word so the result is ready at capture
    lsu_load_align u_load_align (
        .rdata     (bus_rdata),
        .offset    (addr_q[1:0]),
        .load_part (load_part_e'(load_part_q)),
        .load_data (w_aligned)
    );

    // Decode the presented op: store wins over load, illegal codes are no-ops
    always_comb begin
        w_is_store = mem_write_m;
        w_is_load  = mem_read_m & ~mem_write_m;
        w_legal    = 1'b0;
        if (w_is_store) begin
            w_legal = (store_src_e'(store_src_m) != SS_ILL);
        end else if (w_is_load) begin
            w_legal = load_part_legal(load_part_m);
        end
`ifdef LSU_MISALIGN_TRAP_EN
        w_misaligned = 1'b0;
        if (w_is_store) begin
            w_misaligned = ((store_src_e'(store_src_m) == SS_SH) && addr_m[0]) ||
                           ((store_src_e'(store_src_m) == SS_SW) && (addr_m[1:0] != 2'b00));
        end else begin
            w_misaligned = (((load_part_e'(load_part_m) == LP_LH) ||
                             (load_part_e'(load_part_m) == LP_LHU)) && addr_m[0]) ||
                           ((load_part_e'(load_part_m) == LP_LW) && (addr_m[1:0] != 2'b00));
        end
        w_issue = w_legal & ~w_misaligned;
`else
        w_issue = w_legal;
`endif
    end

    // Store lane steering: byte enables and replicated write data
    always_comb begin
        w_st_be    = 4'b0000;
        w_st_wdata = 32'h0000_0000;
        case (store_src_e'(store_src_m))
            SS_SW: begin
                w_st_be    = c_BE_WORD;
                w_st_wdata = wdata_m;
            end
            SS_SH: begin
                w_st_be    = addr_m[1] ? c_BE_HALF_HI : c_BE_HALF_LO;
                w_st_wdata = {2{wdata_m[15:0]}};
            end
            SS_SB: begin
                w_st_be    = c_BE_BYTE0 << addr_m[1:0];
                w_st_wdata = {4{wdata_m[7:0]}};
            end
            default: begin
                w_st_be    = 4'b0000;
                w_st_wdata = 32'h0000_0000;
            end
        endcase
    end

    // Timeout fires on the REQ cycle that would bring the count to the limit
    always_comb begin
        w_cnt_inc = cnt_q + 1'b1;
        w_timeout = (TIMEOUT_CYCLES != 0) && (w_cnt_inc == c_TIMEOUT);
    end

    // Transaction FSM: next state and captured bus/result fields
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        load_part_d  = load_part_q;
        load_data_d  = load_data_q;
        load_valid_d = 1'b0;
        bus_err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (w_issue) begin
                    state_d     = REQ;
                    cnt_d       = '0;
                    we_d        = w_is_store;
                    addr_d      = addr_m;
                    load_part_d = load_part_m;
                    if (w_is_store) begin
                        be_d    = w_st_be;
                        wdata_d = w_st_wdata;
                    end else begin
                        be_d    = c_BE_WORD;
                        wdata_d = 32'h0000_0000;
                    end
                end
            end
            REQ: begin
                if (bus_ready) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    if (!we_q) begin
                        load_valid_d = 1'b1;
                        load_data_d  = w_aligned;
                    end
                end else if (w_timeout) begin
                    state_d     = DONE;
                    cnt_d       = '0;
                    bus_err_d   = 1'b1;
                    load_data_d = 32'h0000_0000;
                end else if (TIMEOUT_CYCLES != 0) begin
                    cnt_d = w_cnt_inc;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and capture registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            be_q         <= 4'b0000;
            wdata_q      <= 32'h0000_0000;
            load_part_q  <= 3'b000;
            load_data_q  <= 32'h0000_0000;
            load_valid_q <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
            load_part_q  <= load_part_d;
            load_data_q  <= load_data_d;
            load_valid_q <= load_valid_d;
            bus_err_q    <= bus_err_d;
        end
    end

    // Bus fields come straight from registers and are quiet outside REQ
    always_comb begin
        bus_req    = (state_q == REQ);
        bus_we     = bus_req & we_q;
        bus_addr   = bus_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
        bus_be     = bus_req ? be_q : 4'b0000;
        bus_wdata  = bus_req ? wdata_q : 32'h0000_0000;
        stall_m    = ((state_q == IDLE) && w_issue) || (state_q == REQ);
        load_data  = load_data_q;
        load_valid = load_valid_q;
        bus_err    = bus_err_q;
`ifdef LSU_MISALIGN_TRAP_EN
        misalign   = (state_q == IDLE) && w_legal && w_misaligned;
`endif
    end

endmodule
`default_nettype wire
